// File: rtl/flash_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_arbiter_pkg
//  Description : Shared constants and types for the two-port flash-bus
//                arbiter: engine command encodings and the FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package flash_bus_arbiter_pkg;

    // Engine direction encodings
    localparam logic FL_CMD_READ  = 1'b0;
    localparam logic FL_CMD_WRITE = 1'b1;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fsm_state_t;

    // Round-robin pointer hand-off: after serving a port, favour the other one
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_arbiter_if
//  Description : Requester and flash-bus engine signals of the arbiter,
//                grouped as one bundle. slave = arbiter side,
//                master = requesters/engine side.
//  Revision    : 1.0  initial release
// ============================================================================
interface flash_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Requester port 0 (UART command path)
    logic          req0;
    logic          cmd0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdat0;
    logic          done0;
    logic          err0;
    // Requester port 1 (display-refresh reader)
    logic          req1;
    logic          cmd1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdat1;
    logic          done1;
    logic          err1;
    // Shared read-data return
    logic [DW-1:0] rdat;
    // Flash-bus engine handshake
    logic          fb_start;
    logic          fb_cmd;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_wdat;
    logic [DW-1:0] fb_rdat;
    logic          fb_done;
    logic          busy;

    modport slave (
        input  req0, cmd0, addr0, wdat0,
        input  req1, cmd1, addr1, wdat1,
        input  fb_rdat, fb_done,
        output done0, err0, done1, err1, rdat,
        output fb_start, fb_cmd, fb_addr, fb_wdat, busy
    );

    modport master (
        output req0, cmd0, addr0, wdat0,
        output req1, cmd1, addr1, wdat1,
        output fb_rdat, fb_done,
        input  done0, err0, done1, err1, rdat,
        input  fb_start, fb_cmd, fb_addr, fb_wdat, busy
    );

endinterface
`default_nettype wire

// File: rtl/flash_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : flash_arb_rr_pick
//  Description : Combinational two-way round-robin pick. A lone request
//                always wins; on contention the pointer decides.
//  Revision    : 1.0  initial release
// ============================================================================
module flash_arb_rr_pick (
    input  wire logic i_req0,
    input  wire logic i_req1,
    input  wire logic i_rr_ptr,
    output logic      o_gnt_valid,
    output logic      o_gnt_idx
);

    // Grant index: pointer on contention, otherwise whichever port is asking
    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        o_gnt_idx   = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt_idx = i_rr_ptr;
        end else if (i_req1) begin
            o_gnt_idx = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_arbiter
//  Description : Shares one flash-bus engine between two requesters.
//                Round-robin grant, operand latch at grant, one engine
//                transaction per grant, done/err pulse back to the owner,
//                and abort of hung transactions on a WAIT timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module flash_bus_arbiter
    import flash_bus_arbiter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  wire logic            CLK_50MHZ,
    input  wire logic            RST,
    flash_bus_arbiter_if.slave   bus
);

    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT);

    fsm_state_t    r_state;
    fsm_state_t    w_state_nxt;
    logic          r_rr;
    logic          r_owner;
    logic          r_err;
    logic          r_fb_cmd;
    logic [AW-1:0] r_fb_addr;
    logic [DW-1:0] r_fb_wdat;
    logic [DW-1:0] r_rdat;
    logic [TW-1:0] r_timer;

    logic          w_gnt_valid;
    logic          w_gnt_idx;
    logic [TW-1:0] w_timer_inc;
    logic          w_timeout;

    flash_arb_rr_pick u_rr_pick (
        .i_req0      (bus.req0),
        .i_req1      (bus.req1),
        .i_rr_ptr    (r_rr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT,
    // so the abort lands exactly TIMEOUT cycles after WAIT entry
    assign w_timer_inc = r_timer + TW'(1);
    assign w_timeout   = (TIMEOUT != 0) && (w_timer_inc == c_TIMEOUT);

    // State register
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; fb_done is only honoured in WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.fb_done || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch at grant, completion capture, timer, rr update
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_rr      <= 1'b0;
            r_owner   <= 1'b0;
            r_err     <= 1'b0;
            r_fb_cmd  <= FL_CMD_READ;
            r_fb_addr <= '0;
            r_fb_wdat <= '0;
            r_rdat    <= '0;
            r_timer   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner   <= w_gnt_idx;
                        r_fb_cmd  <= w_gnt_idx ? bus.cmd1  : bus.cmd0;
                        r_fb_addr <= w_gnt_idx ? bus.addr1 : bus.addr0;
                        r_fb_wdat <= w_gnt_idx ? bus.wdat1 : bus.wdat0;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    // A same-cycle fb_done beats the timeout
                    if (bus.fb_done) begin
                        r_rdat <= bus.fb_rdat;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdat <= '0;
                        r_err  <= 1'b1;
                    end
                    if (r_timer != c_TIMEOUT) begin
                        r_timer <= w_timer_inc;
                    end
                end
                ST_RESP: begin
                    // Engine-facing operands are parked at zero while idle
                    r_rr      <= other_port(r_owner);
                    r_fb_cmd  <= FL_CMD_READ;
                    r_fb_addr <= '0;
                    r_fb_wdat <= '0;
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign bus.fb_start = (r_state == ST_ISSUE);
    assign bus.fb_cmd   = r_fb_cmd;
    assign bus.fb_addr  = r_fb_addr;
    assign bus.fb_wdat  = r_fb_wdat;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.rdat     = r_rdat;
    assign bus.done0    = (r_state == ST_RESP) && !r_owner;
    assign bus.done1    = (r_state == ST_RESP) &&  r_owner;
    assign bus.err0     = bus.done0 && r_err;
    assign bus.err1     = bus.done1 && r_err;

endmodule
`default_nettype wire
